seg_scan_capture: RTL and testbench

Receive-side counterpart of the time-multiplexed hex display driver. It samples the 3-bit digit select `seg_an` and 4-bit nibble `seg_data` of a scanning display and filters out glitches. It then reconstructs the 32-bit word being displayed and the per-digit enable mask, publishing one snapshot per fixed frame window. It is used on the board as a loop-back checker and in benches as the scoreboard front end for any block driving the display bus.

---
 rtl/seg_scan_capture.sv | 139 +++++++++++++
 tb/tb_seg_scan_capture.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_capture
//  Purpose  : Receive side of a time-multiplexed hex display bus. Samples the
//             digit select / nibble pair, rejects short glitches, rebuilds the
//             displayed 32-bit word plus per-digit enable mask and publishes
//             one snapshot per fixed frame window.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    STABLE_CYCLES : identical samples needed before a digit is accepted (2..255)
//    FRAME_CYCLES  : capture window length in clk cycles (>= 8*(STABLE_CYCLES+3))
//  Ports
//    clk        : system clock, all state on rising edge
//    rst        : asynchronous active-low reset
//    seg_an     : observed digit select (asynchronous to clk)
//    seg_data   : observed hex nibble   (asynchronous to clk)
//    data_out   : last published word, nibble i = value shown on digit i
//    valid_out  : last published mask, bit i = digit i accepted in window
//    frame_done : one-cycle pulse on the cycle after a publication
//    changed    : with frame_done, publication differs from the previous one
// ============================================================================
module seg_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_CYCLES  = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  seg_an,
    input  logic [3:0]  seg_data,
    output logic [31:0] data_out,
    output logic [7:0]  valid_out,
    output logic        frame_done,
    output logic        changed
);

    localparam int             TW          = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [TW-1:0]  C_TIMER_LAST = TW'(FRAME_CYCLES - 1);
    localparam logic [7:0]     C_RUN_MAX    = 8'(STABLE_CYCLES);

    // Synchronizer and stability filter state; {an, data} packed as [6:4],[3:0]
    logic [6:0]    sync1_q, sync2_q;
    logic [6:0]    prev_q;
    logic [7:0]    run_q, run_d;

    // Per-window capture
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    seen_q, seen_d;
    logic [TW-1:0] timer_q, timer_d;

    // Registered outputs
    logic [31:0]   data_q;
    logic [7:0]    valid_q;
    logic          frame_done_q;
    logic          changed_q;

    logic          w_same;
    logic          w_accept;
    logic          w_publish;
    logic [31:0]   w_pub_data;

    assign w_same    = (sync2_q == prev_q);
    // Fires only on the transition into saturation, so a held value never re-fires
    assign w_accept  = w_same && (run_q == C_RUN_MAX - 8'd1);
    assign w_publish = (timer_q == C_TIMER_LAST);

    always_comb begin
        run_d = run_q;
        if (!w_same) begin
            run_d = 8'd1;
        end else if (run_q < C_RUN_MAX) begin
            run_d = run_q + 8'd1;
        end
    end

    // "Next" capture state includes an accept on the current edge, so an accept
    // coinciding with the publish edge still lands in the closing frame.
    always_comb begin
        shadow_d = shadow_q;
        seen_d   = seen_q;
        if (w_accept) begin
            shadow_d[{prev_q[6:4], 2'b00} +: 4] = prev_q[3:0];
            seen_d[prev_q[6:4]]                 = 1'b1;
        end
    end

    always_comb begin
        w_pub_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (seen_d[i]) begin
                w_pub_data[4*i +: 4] = shadow_d[4*i +: 4];
            end
        end
    end

    assign timer_d = w_publish ? '0 : timer_q + TW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            run_q        <= '0;
            shadow_q     <= '0;
            seen_q       <= '0;
            timer_q      <= '0;
            data_q       <= '0;
            valid_q      <= '0;
            frame_done_q <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            sync1_q <= {seg_an, seg_data};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            run_q   <= run_d;
            timer_q <= timer_d;
            if (w_publish) begin
                data_q       <= w_pub_data;
                valid_q      <= seen_d;
                changed_q    <= ({w_pub_data, seen_d} != {data_q, valid_q});
                frame_done_q <= 1'b1;
                shadow_q     <= '0;
                seen_q       <= '0;
            end else begin
                frame_done_q <= 1'b0;
                changed_q    <= 1'b0;
                shadow_q     <= shadow_d;
                seen_q       <= seen_d;
            end
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign frame_done = frame_done_q;
    assign changed    = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_capture
//  Purpose  : Self-checking bench for seg_scan_capture (STABLE=4, FRAME=64).
//             A reference model recomputes every publication from the raw
//             sampled input stream using run-length rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_capture;

    localparam int S = 4;
    localparam int F = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  seg_an = 3'd0;
    logic [3:0]  seg_data = 4'h1;
    logic [31:0] data_out;
    logic [7:0]  valid_out;
    logic        frame_done;
    logic        changed;

    seg_scan_capture #(.STABLE_CYCLES(S), .FRAME_CYCLES(F)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_an     (seg_an),
        .seg_data   (seg_data),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .frame_done (frame_done),
        .changed    (changed)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] stamp;
        logic [31:0] data;
        logic [7:0]  valid;
        logic        chg;
    } frame_t;

    frame_t obs_q[$];
    frame_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fill_idx = 0;

    // ---------------- reference model ----------------
    // The filter sees the input twice-delayed (reset value 0 for the first two
    // edges). A digit is accepted on the edge where the run of identical
    // delayed samples, counted since reset, reaches exactly S.
    int          m_n = 0;
    logic [6:0]  m_x[$];
    logic [6:0]  m_y[$];
    logic [3:0]  m_nib[8];
    logic [7:0]  m_seen = '0;
    logic [39:0] m_last = '0;

    task automatic model_step();
        logic [6:0]  y;
        int          r;
        frame_t      f;
        logic [31:0] w;
        cyc = cyc + 1;
        if (!rst) begin
            m_n = 0;
            m_x.delete();
            m_y.delete();
            m_seen = '0;
            m_last = '0;
            for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
        end else begin
            m_n = m_n + 1;
            y = (m_x.size() >= 2) ? m_x[m_x.size()-2] : 7'd0;
            m_x.push_back({seg_an, seg_data});
            if (m_x.size() > 3) void'(m_x.pop_front());
            m_y.push_back(y);
            if (m_y.size() > S + 1) void'(m_y.pop_front());
            r = 0;
            for (int k = m_y.size() - 1; k >= 0; k--) begin
                if (m_y[k] !== y) break;
                r++;
            end
            if (r == S) begin
                m_nib[y[6:4]]  = y[3:0];
                m_seen[y[6:4]] = 1'b1;
            end
            if (m_n % F == 0) begin
                w = '0;
                for (int i = 0; i < 8; i++) if (m_seen[i]) w[4*i +: 4] = m_nib[i];
                f.stamp = 32'(cyc);
                f.data  = w;
                f.valid = m_seen;
                f.chg   = ({w, m_seen} != m_last);
                m_last  = {w, m_seen};
                exp_q.push_back(f);
                m_seen = '0;
                for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Record every DUT publication pulse, stamped with the edge count
    initial forever begin
        frame_t o;
        @(negedge clk);
        if (frame_done === 1'b1) begin
            o = {32'(cyc), data_out, valid_out, changed};
            obs_q.push_back(o);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [2:0] an, input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            seg_an   = an;
            seg_data = d;
            @(negedge clk);
            #1;
        end
    endtask

    // One-cycle changing values: never stable long enough to be accepted
    task automatic filler(input int n);
        for (int i = 0; i < n; i++) begin
            drive(3'(fill_idx % 8), 4'h0, 1);
            fill_idx++;
        end
    endtask

    task automatic scan_n(input logic [31:0] word, input int ndig, input int hold, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int d;
            d = (c / hold) % ndig;
            drive(3'(d), word[4*d +: 4], 1);
        end
    endtask

    task automatic scan_frames(input logic [31:0] word, input int ndig, input int hold,
                               input int nfr, output bit ok);
        int c;
        c = 0;
        while (obs_q.size() < nfr && c < 20 * F) begin
            int d;
            d = (c / hold) % ndig;
            drive(3'(d), word[4*d +: 4], 1);
            c++;
        end
        ok = (obs_q.size() >= nfr);
    endtask

    task automatic fill_frames(input int nfr, output bit ok);
        int c;
        c = 0;
        while (obs_q.size() < nfr && c < 20 * F) begin
            filler(1);
            c++;
        end
        ok = (obs_q.size() >= nfr);
    endtask

    task automatic clear_q();
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_out); end
        checks++; if (valid_out !== 8'h0) begin errors++; $display("FAIL reset_valid: got %h expected 0", valid_out); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b expected 0", changed); end
    endtask

    task automatic test_full_scan();
        bit ok;
        clear_q();
        seg_an = 3'd0; seg_data = 4'h1;
        rst = 1'b1;
        scan_frames(32'h22111711, 8, 6, 2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout: got %0d frames expected 2", obs_q.size()); end
        for (int k = 0; k < 2; k++) begin
            if (obs_q.size() > k && exp_q.size() > k) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL full_model%0d: got %h expected %h", k, obs_q[k], exp_q[k]); end
            end
        end
        if (ok) begin
            checks++; if (obs_q[0].data !== 32'h22111711) begin errors++; $display("FAIL full_data0: got %h expected 22111711", obs_q[0].data); end
            checks++; if (obs_q[0].valid !== 8'hFF) begin errors++; $display("FAIL full_valid0: got %h expected ff", obs_q[0].valid); end
            checks++; if (obs_q[0].chg !== 1'b1) begin errors++; $display("FAIL full_chg0: got %b expected 1", obs_q[0].chg); end
            checks++; if (obs_q[1].data !== 32'h22111711 || obs_q[1].valid !== 8'hFF) begin
                errors++; $display("FAIL full_frame1: got %h/%h expected 22111711/ff", obs_q[1].data, obs_q[1].valid); end
            checks++; if (obs_q[1].chg !== 1'b0) begin errors++; $display("FAIL full_chg1: got %b expected 0", obs_q[1].chg); end
        end
    endtask

    task automatic test_partial_mask();
        bit ok;
        clear_q();
        scan_frames(32'h22111711, 4, 6, 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL partial_timeout: got %0d frames expected 1", obs_q.size()); end
        if (ok && exp_q.size() > 0) begin
            checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL partial_model: got %h expected %h", obs_q[0], exp_q[0]); end
            checks++; if (obs_q[0].valid !== 8'h0F) begin errors++; $display("FAIL partial_valid: got %h expected 0f", obs_q[0].valid); end
            checks++; if (obs_q[0].data !== 32'h00001711) begin errors++; $display("FAIL partial_data: got %h expected 00001711", obs_q[0].data); end
            checks++; if (obs_q[0].chg !== 1'b1) begin errors++; $display("FAIL partial_chg: got %b expected 1", obs_q[0].chg); end
        end
        filler(1);
        checks++; if (frame_done !== 1'b0 || changed !== 1'b0) begin
            errors++; $display("FAIL pulse_width: got fd=%b chg=%b expected 0/0", frame_done, changed); end
    endtask

    task automatic test_glitch();
        bit ok;
        clear_q();
        scan_frames(32'h22111711, 8, 3, 2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL glitch_timeout: got %0d frames expected 2", obs_q.size()); end
        for (int k = 0; k < 2; k++) begin
            if (obs_q.size() > k && exp_q.size() > k) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL glitch_model%0d: got %h expected %h", k, obs_q[k], exp_q[k]); end
            end
        end
        if (ok) begin
            checks++; if (obs_q[1].valid !== 8'h00 || obs_q[1].data !== 32'h0) begin
                errors++; $display("FAIL glitch_empty: got %h/%h expected 0/00", obs_q[1].data, obs_q[1].valid); end
        end
        clear_q();
        filler(12);
        drive(3'd2, 4'h7, 5);
        fill_frames(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d frames expected 1", obs_q.size()); end
        if (ok && exp_q.size() > 0) begin
            checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_model: got %h expected %h", obs_q[0], exp_q[0]); end
            checks++; if (obs_q[0].valid !== 8'h04 || obs_q[0].data !== 32'h00000700) begin
                errors++; $display("FAIL single_digit: got %h/%h expected 00000700/04", obs_q[0].data, obs_q[0].valid); end
        end
    endtask

    task automatic test_overwrite();
        bit ok;
        clear_q();
        filler(6);
        drive(3'd5, 4'h3, 6);
        filler(6);
        drive(3'd5, 4'h9, 6);
        fill_frames(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL overwrite_timeout: got %0d frames expected 1", obs_q.size()); end
        if (ok && exp_q.size() > 0) begin
            checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL overwrite_model: got %h expected %h", obs_q[0], exp_q[0]); end
            checks++; if (obs_q[0].valid !== 8'h20 || obs_q[0].data !== 32'h00900000) begin
                errors++; $display("FAIL overwrite_value: got %h/%h expected 00900000/20", obs_q[0].data, obs_q[0].valid); end
        end
    endtask

    task automatic test_edge_race();
        bit ok;
        // Accept timed onto the publish edge: belongs to the closing frame
        clear_q();
        filler(58);
        drive(3'd0, 4'hA, 8);
        fill_frames(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL race_timeout: got %0d frames expected 2", obs_q.size()); end
        if (ok && exp_q.size() > 1) begin
            checks++; if (obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
                errors++; $display("FAIL race_model: got %h,%h expected %h,%h", obs_q[0], obs_q[1], exp_q[0], exp_q[1]); end
            checks++; if (obs_q[0].valid !== 8'h01 || obs_q[0].data !== 32'h0000000A) begin
                errors++; $display("FAIL race_on_edge: got %h/%h expected 0000000a/01", obs_q[0].data, obs_q[0].valid); end
            checks++; if (obs_q[1].valid !== 8'h00 || obs_q[1].chg !== 1'b1) begin
                errors++; $display("FAIL race_after: got valid=%h chg=%b expected 00/1", obs_q[1].valid, obs_q[1].chg); end
        end
        // One edge later: belongs to the following frame
        clear_q();
        filler(59);
        drive(3'd0, 4'hA, 8);
        fill_frames(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL late_timeout: got %0d frames expected 2", obs_q.size()); end
        if (ok && exp_q.size() > 1) begin
            checks++; if (obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
                errors++; $display("FAIL late_model: got %h,%h expected %h,%h", obs_q[0], obs_q[1], exp_q[0], exp_q[1]); end
            checks++; if (obs_q[0].valid !== 8'h00 || obs_q[0].chg !== 1'b0) begin
                errors++; $display("FAIL late_closing: got valid=%h chg=%b expected 00/0", obs_q[0].valid, obs_q[0].chg); end
            checks++; if (obs_q[1].valid !== 8'h01 || obs_q[1].data !== 32'h0000000A) begin
                errors++; $display("FAIL late_next: got %h/%h expected 0000000a/01", obs_q[1].data, obs_q[1].valid); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int rel;
        clear_q();
        scan_n(32'h89ABCDEF, 8, 4, 32);
        rst = 1'b0;
        #1;
        checks++; if (data_out !== 32'h0 || valid_out !== 8'h0 || frame_done !== 1'b0 || changed !== 1'b0) begin
            errors++; $display("FAIL midreset_async: got %h/%h/%b/%b expected all 0", data_out, valid_out, frame_done, changed); end
        @(negedge clk); #1;
        @(negedge clk); #1;
        clear_q();
        rel = cyc;
        seg_an = 3'd0; seg_data = 4'h1;
        rst = 1'b1;
        scan_frames(32'h22111711, 4, 6, 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_timeout: got %0d frames expected 1", obs_q.size()); end
        if (ok && exp_q.size() > 0) begin
            checks++; if (obs_q[0].stamp !== 32'(rel + F)) begin
                errors++; $display("FAIL midreset_latency: got %0d expected %0d", obs_q[0].stamp, rel + F); end
            checks++; if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL midreset_model: got %h expected %h", obs_q[0], exp_q[0]); end
            checks++; if (obs_q[0].valid !== 8'h0F || obs_q[0].data !== 32'h00001711 || obs_q[0].chg !== 1'b1) begin
                errors++; $display("FAIL midreset_discard: got %h/%h/%b expected 00001711/0f/1", obs_q[0].data, obs_q[0].valid, obs_q[0].chg); end
        end
    endtask

    task automatic test_random();
        int c;
        clear_q();
        c = 0;
        while (obs_q.size() < 3 && c < 20 * F) begin
            int n;
            n = int'($urandom_range(1, 8));
            drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), n);
            c += n;
        end
        checks++; if (obs_q.size() < 3) begin errors++; $display("FAIL random_timeout: got %0d frames expected 3", obs_q.size()); end
        for (int k = 0; k < 3; k++) begin
            if (obs_q.size() > k && exp_q.size() > k) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL random_model%0d: got %h expected %h", k, obs_q[k], exp_q[k]); end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk); #1;
        test_reset();
        test_full_scan();
        test_partial_mask();
        test_glitch();
        test_overwrite();
        test_edge_race();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
